// File: rtl/side_ch_pkg.sv
// Shared types and constants for the side-channel IQ capture front end.
package side_ch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_CAPTURE = 2'd2
   } side_ch_state_t;

   localparam logic [15:0] SIDE_CH_HDR_MAGIC = 16'hA5C3;

   localparam int unsigned HDR_FIELD_W   = 16;
   localparam int unsigned HDR_MAGIC_LSB = 48;
   localparam int unsigned HDR_SEQ_LSB   = 32;
   localparam int unsigned HDR_LEN_LSB   = 16;
   localparam int unsigned HDR_W         = 64;

   // Header word: magic | sequence | zero-extended length | reserved zero.
   function automatic logic [HDR_W-1:0] side_ch_header(input logic [HDR_FIELD_W-1:0] seq,
                                                       input logic [HDR_FIELD_W-1:0] len);
      logic [HDR_W-1:0] hdr;
      hdr = '0;
      hdr[HDR_MAGIC_LSB +: HDR_FIELD_W] = SIDE_CH_HDR_MAGIC;
      hdr[HDR_SEQ_LSB   +: HDR_FIELD_W] = seq;
      hdr[HDR_LEN_LSB   +: HDR_FIELD_W] = len;
      return hdr;
   endfunction

endpackage

// File: rtl/side_ch_iq_pair_packer.sv
// Packs two consecutive IQ samples into one word; first sample lands in the low half.
module side_ch_iq_pair_packer #(
   parameter int unsigned IQ_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr,
   input  logic                  in_valid,
   input  logic [IQ_WIDTH-1:0]   iq,
   output logic [2*IQ_WIDTH-1:0] word,
   output logic                  word_valid
);

   logic [IQ_WIDTH-1:0] low_q;
   logic                phase_q;

   // Word is formed combinationally so the parent can register it in the same cycle.
   assign word       = {iq, low_q};
   assign word_valid = in_valid && phase_q && !clr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         low_q   <= '0;
         phase_q <= 1'b0;
      end else if (clr) begin
         phase_q <= 1'b0;
      end else if (in_valid) begin
         if (!phase_q) low_q <= iq;
         phase_q <= !phase_q;
      end
   end

endmodule

// File: rtl/side_ch_iq_capture.sv
// Triggered IQ capture: one header word, then sample pairs into the side-channel FIFO.
module side_ch_iq_capture
   import side_ch_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH           = 64,
   parameter int unsigned IQ_WIDTH               = 32,
   parameter int unsigned MAX_BIT_NUM_DMA_SYMBOL = 14,
   parameter int unsigned SEQ_WIDTH              = 16
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              capture_en,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] capture_len,
   input  logic                              trigger,
   input  logic [IQ_WIDTH-1:0]               iq,
   input  logic                              iq_valid,
   input  logic                              fulln_to_pl,
   output logic [C_DATA_WIDTH-1:0]           data_to_ps,
   output logic                              data_to_ps_valid,
   output logic                              busy,
   output logic [SEQ_WIDTH-1:0]              seq_num,
   output logic [15:0]                       drop_cnt,
   output logic                              overflow,
   input  logic                              clr_status
);

   localparam int unsigned LW = MAX_BIT_NUM_DMA_SYMBOL;

   side_ch_state_t state_q, state_d;
   logic [LW-1:0]           len_q;
   logic [LW-1:0]           word_cnt_q;
   logic [LW-1:0]           cnt_inc_c;
   logic [SEQ_WIDTH-1:0]    seq_inc_c;
   logic [C_DATA_WIDTH-1:0] hdr_c;
   logic [2*IQ_WIDTH-1:0]   pair_word;
   logic                    pair_valid;
   logic                    start_c, abort_c, pack_in_c, emit_c, last_c;

   assign start_c   = (state_q == ST_IDLE) && trigger && capture_en;
   assign abort_c   = (state_q != ST_IDLE) && !capture_en;
   assign pack_in_c = (state_q == ST_CAPTURE) && capture_en && iq_valid;
   assign emit_c    = start_c || pair_valid;
   assign cnt_inc_c = word_cnt_q + LW'(1);
   assign last_c    = pair_valid && (cnt_inc_c == len_q);
   assign seq_inc_c = seq_num + SEQ_WIDTH'(1);
   assign hdr_c     = C_DATA_WIDTH'(side_ch_header(HDR_FIELD_W'(seq_inc_c), HDR_FIELD_W'(capture_len)));

   side_ch_iq_pair_packer #(
      .IQ_WIDTH (IQ_WIDTH)
   ) u_packer (
      .clk        (clk),
      .rstn       (rstn),
      .clr        (start_c || abort_c),
      .in_valid   (pack_in_c),
      .iq         (iq),
      .word       (pair_word),
      .word_valid (pair_valid)
   );

   // Next-state logic; an abort always wins over progress.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (start_c) state_d = ST_HEADER;
         ST_HEADER:  if (!capture_en || len_q == '0) state_d = ST_IDLE;
                     else state_d = ST_CAPTURE;
         ST_CAPTURE: if (!capture_en || last_c) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q          <= ST_IDLE;
         len_q            <= '0;
         word_cnt_q       <= '0;
         seq_num          <= '0;
         data_to_ps       <= '0;
         data_to_ps_valid <= 1'b0;
         busy             <= 1'b0;
         drop_cnt         <= '0;
         overflow         <= 1'b0;
      end else begin
         state_q          <= state_d;
         busy             <= (state_d != ST_IDLE);
         data_to_ps_valid <= emit_c && fulln_to_pl;

         if (start_c) begin
            len_q      <= capture_len;
            seq_num    <= seq_inc_c;
            word_cnt_q <= '0;
            data_to_ps <= hdr_c;
         end else if (pair_valid) begin
            word_cnt_q <= cnt_inc_c;
            data_to_ps <= C_DATA_WIDTH'(pair_word);
         end

         // Status clear takes priority over a simultaneous drop.
         if (clr_status) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
         end else if (emit_c && !fulln_to_pl) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule
